// File: rtl/keyboard_writer.sv
// keyboard_writer: PS/2 host-to-device transmitter. Sends one command byte over the
// open-drain clock/data pair and reports device ACK, missing ACK or edge timeout.
module keyboard_writer #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned EDGE_TIMEOUT   = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       fastClk,
  input  logic       rst,
  inout  wire        ps2CLK,
  inout  wire        ps2DATA,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       txActive,
  output logic       done,
  output logic       ack,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAckChk,
    StWaitIdle
  } state_e;

  localparam int unsigned CntMax = (INHIBIT_CYCLES > EDGE_TIMEOUT) ? INHIBIT_CYCLES
                                                                     : EDGE_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned FcW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] InhLoad  = CntW'(INHIBIT_CYCLES);
  localparam logic [CntW-1:0] TmoLoad  = CntW'(EDGE_TIMEOUT);
  localparam logic [FcW-1:0]  FiltLast = FcW'(FILTER_LEN - 1);

  // Input conditioning
  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           clk_filt_q, clk_filt_d;
  logic [FcW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fe_q, fe_d;

  // Transmit state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            ack_reg_q, ack_reg_d;
  logic            clk_low_q, clk_low_d;
  logic            data_low_q, data_low_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  // Open-drain drivers: pull low or release, never drive high.
  assign ps2CLK  = clk_low_q  ? 1'b0 : 1'bz;
  assign ps2DATA = data_low_q ? 1'b0 : 1'bz;

  assign busy     = busy_q;
  assign txActive = busy_q;
  assign done     = done_q;
  assign ack      = ack_q;
  assign err      = err_q;

  // Clock glitch filter: level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FiltLast) begin
        clk_filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FcW'(1);
      end
    end
    fe_d = clk_filt_q & ~clk_filt_d;
  end

  // Next-state and output logic of the transmit sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ack_reg_d  = ack_reg_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        // A start coinciding with the done pulse belongs to the finished attempt.
        if (start && !done_q) begin
          shreg_d   = data;
          cnt_d     = InhLoad;
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        clk_low_d  = 1'b1;
        data_low_d = 1'b0;
        if (cnt_q <= CntW'(1)) begin
          data_low_d = 1'b1;
          state_d    = StReq;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StReq: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b1;
        bit_cnt_d  = '0;
        cnt_d      = TmoLoad;
        state_d    = StSend;
      end
      StSend: begin
        if (fe_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd10) begin
            state_d = StAckChk;
          end else if (bit_cnt_q < 4'd8) begin
            data_low_d = ~shreg_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            // Odd parity bit is ~^shreg; pull low when it is 0.
            data_low_d = ^shreg_q;
          end else begin
            data_low_d = 1'b0;
          end
        end
      end
      StAckChk: begin
        ack_reg_d = ~dat_s2_q;
        state_d   = StWaitIdle;
      end
      StWaitIdle: begin
        if (clk_filt_q && dat_s2_q) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          done_d     = 1'b1;
          ack_d      = ack_reg_q;
          err_d      = ~ack_reg_q;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Edge watchdog shared by all device-clocked states; timeout overrides completion.
    if (state_q inside {StSend, StAckChk, StWaitIdle}) begin
      if (fe_q) begin
        cnt_d = TmoLoad;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end else begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        done_d     = 1'b1;
        ack_d      = 1'b0;
        err_d      = 1'b1;
        state_d    = StIdle;
      end
    end
  end

  // State registers with synchronous reset; idle bus levels are high.
  always_ff @(posedge fastClk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fe_q       <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ack_reg_q  <= 1'b0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2CLK;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2DATA;
      dat_s2_q   <= dat_s1_q;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      fe_q       <= fe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ack_reg_q  <= ack_reg_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_keyboard_writer.sv
// tb_keyboard_writer: directed bench with a simple PS/2 device model on pulled-up lines.
module tb_keyboard_writer;

  localparam int unsigned InhCycles = 50;
  localparam int unsigned EdgeTmo   = 1000;
  localparam int unsigned FiltLen   = 4;
  localparam int unsigned Half      = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       start;
  logic       busy, tx_active, done, ack, err;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_done   = 0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  keyboard_writer #(
    .INHIBIT_CYCLES(InhCycles),
    .EDGE_TIMEOUT  (EdgeTmo),
    .FILTER_LEN    (FiltLen)
  ) dut (
    .fastClk (clk),
    .rst     (rst),
    .ps2CLK  (ps2_clk),
    .ps2DATA (ps2_data),
    .data    (data),
    .start   (start),
    .busy    (busy),
    .txActive(tx_active),
    .done    (done),
    .ack     (ack),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    data  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the host inhibit and its clock release; reports inhibit length.
  task automatic wait_release(output int unsigned low_len, output logic last_data,
                              output logic ok);
    int unsigned n = 0;
    ok        = 1'b0;
    low_len   = 0;
    last_data = 1'b1;
    while (ps2_clk !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ps2_clk !== 1'b0) return;
    n = 0;
    while (ps2_clk === 1'b0 && n < 1000) begin
      last_data = ps2_data;
      n++;
      @(negedge clk);
    end
    low_len = n;
    ok      = (ps2_clk === 1'b1);
  endtask

  // Device clocks n_bits falling edges; seen[i] is DATA during the high phase before edge i+1.
  task automatic dev_frame(input logic do_ack, input int unsigned n_bits,
                           output logic [10:0] seen, output int unsigned low_len,
                           output logic last_data);
    logic ok;
    seen = '1;
    wait_release(low_len, last_data, ok);
    check_eq("req_release", {31'd0, ok}, 32'd1);
    for (int i = 0; i < n_bits; i++) begin
      repeat (Half) @(negedge clk);
      seen[i] = ps2_data;
      if (i == 10 && do_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    if (n_bits == 11 && do_ack) begin
      repeat (Half) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(output logic got, output logic ack_v, output logic err_v,
                           output logic busy_v);
    int unsigned n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    got    = (done === 1'b1);
    ack_v  = ack;
    err_v  = err;
    busy_v = busy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] seen;
    int unsigned low_len, n, d0;
    logic        last_data, got, ack_v, err_v, busy_v, ok;

    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_txactive", {31'd0, tx_active}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);

    // 0xED with ACK: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    pulse_start(8'hED);
    check_eq("ed_busy_rise", {31'd0, busy}, 32'd1);
    check_eq("ed_txactive", {31'd0, tx_active}, 32'd1);
    dev_frame(1'b1, 11, seen, low_len, last_data);
    check_eq("ed_inhibit_len", low_len, 32'd51);
    check_eq("ed_req_data_low", {31'd0, last_data}, 32'd0);
    check_eq("ed_frame", {21'd0, seen}, 32'h7DA);
    wait_done(got, ack_v, err_v, busy_v);
    check_eq("ed_done", {31'd0, got}, 32'd1);
    check_eq("ed_ack", {31'd0, ack_v}, 32'd1);
    check_eq("ed_err", {31'd0, err_v}, 32'd0);
    check_eq("ed_busy_at_done", {31'd0, busy_v}, 32'd1);
    @(negedge clk);
    check_eq("ed_done_fall", {31'd0, done}, 32'd0);
    check_eq("ed_busy_fall", {31'd0, busy}, 32'd0);

    // 0x00 then 0x01 back to back; a start held across the done cycle counts only after it.
    pulse_start(8'h00);
    dev_frame(1'b1, 11, seen, low_len, last_data);
    check_eq("b00_frame", {21'd0, seen}, 32'h600);
    wait_done(got, ack_v, err_v, busy_v);
    check_eq("b00_ack", {30'd0, got, ack_v}, 32'd3);
    data  = 8'h01;
    start = 1'b1;
    @(negedge clk);
    check_eq("start_in_done_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_eq("start_after_done_taken", {31'd0, busy}, 32'd1);
    dev_frame(1'b1, 11, seen, low_len, last_data);
    check_eq("b01_frame", {21'd0, seen}, 32'h402);
    wait_done(got, ack_v, err_v, busy_v);
    check_eq("b01_ack", {29'd0, got, ack_v, err_v}, 32'd6);

    // Device never ACKs.
    pulse_start(8'hF4);
    dev_frame(1'b0, 11, seen, low_len, last_data);
    wait_done(got, ack_v, err_v, busy_v);
    check_eq("nack_result", {29'd0, got, ack_v, err_v}, 32'd5);
    @(negedge clk);
    check_eq("nack_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);

    // Device never clocks: error 1001 cycles after clock release.
    pulse_start(8'hEE);
    wait_release(low_len, last_data, ok);
    check_eq("tmo_release", {31'd0, ok}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_latency", n, 32'd1001);
    check_eq("tmo_result", {29'd0, busy, ack, err}, 32'd5);
    check_eq("tmo_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    @(negedge clk);
    check_eq("tmo_busy_done_fall", {30'd0, busy, done}, 32'd0);

    // Start of 0x55 mid-frame of 0xF3 is ignored.
    d0 = n_done;
    pulse_start(8'hF3);
    fork
      dev_frame(1'b1, 11, seen, low_len, last_data);
      begin
        repeat (400) @(negedge clk);
        data  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_eq("mid_frame", {21'd0, seen}, 32'h7E6);
    wait_done(got, ack_v, err_v, busy_v);
    check_eq("mid_ack", {30'd0, got, ack_v}, 32'd3);
    repeat (200) @(negedge clk);
    check_eq("mid_done_count", n_done - d0, 32'd1);
    check_eq("mid_idle", {31'd0, busy}, 32'd0);

    // Reset during bit 4 of 0x00 (DATA actively low), then 0xFF completes.
    pulse_start(8'h00);
    dev_frame(1'b0, 5, seen, low_len, last_data);
    repeat (10) @(negedge clk);
    check_eq("prerst_data_low", {31'd0, ps2_data}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    check_eq("midrst_outs", {27'd0, busy, tx_active, done, ack, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(8'hFF);
    dev_frame(1'b1, 11, seen, low_len, last_data);
    check_eq("ff_frame", {21'd0, seen}, 32'h7FE);
    wait_done(got, ack_v, err_v, busy_v);
    check_eq("ff_result", {29'd0, got, ack_v, err_v}, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_writer.md
# keyboard_writer

PS/2 host-to-device transmitter. Sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) to the keyboard over the same open-drain `ps2CLK`/`ps2DATA` pair used by `KeyboardReader`. It runs on `fastClk` alongside the reader, which must ignore the bus while `txActive` is high. It reports device acknowledge, no-acknowledge and timeout to the requester.

## Interface

Parameters:
- `INHIBIT_CYCLES`, default 5000: cycles `ps2CLK` is held low before the start bit (100 µs at 50 MHz).
- `EDGE_TIMEOUT`, default 750000: maximum cycles allowed to the first falling edge and between successive falling edges (15 ms at 50 MHz).
- `FILTER_LEN`, default 8: consecutive identical synchronized samples needed to change the filtered `ps2CLK` level.

Ports:
- `fastClk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `ps2CLK` inout 1: open-drain. The block drives 0 or Z only.
- `ps2DATA` inout 1: open-drain. The block drives 0 or Z only.
- `data` input 8: byte to send. Latched on an accepted `start`.
- `start` input 1: single-cycle request. Honoured only in IDLE.
- `busy` output 1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `txActive` output 1: equals `busy`. Routed to the reader as its ignore input.
- `done` output 1: one-cycle pulse at the end of every attempt.
- `ack` output 1: valid while `done` is high. 1 = device acknowledged.
- `err` output 1: one-cycle pulse with `done` on timeout or missing ACK.

## Operation

- Input conditioning:
  - Both lines pass through a 2-flop synchronizer.
  - `ps2CLK` is additionally filtered by `FILTER_LEN`; the filtered level resets to 1.
  - A falling edge (`fe`) is filtered high→low, one cycle wide.
  - `ps2DATA` is used synchronized only.
- Drive registers `clkLow`, `dataLow` (1 = pull low): `ps2CLK = clkLow ? 0 : Z`, and likewise for DATA. Both reset to 0 (released).
- Frame: start 0, D0..D7 LSB first, odd parity (`~^data`), stop 1, then device ACK 0.
- States and transitions:
  - IDLE: lines released. `start` latches `data` into `shreg`, loads the counter with `INHIBIT_CYCLES`, goes to INHIBIT.
  - INHIBIT: `clkLow=1`, `dataLow=0`. Counter decrements. At 0 goes to REQ.
  - REQ, one cycle: `clkLow=1`, `dataLow=1` (start bit). Then goes to SEND with `clkLow=0`, `bitCnt=0`, timeout counter loaded.
  - SEND: each `fe` drives bit `bitCnt` (0–7 data, 8 parity, 9 stop = release) and increments `bitCnt`. The `fe` after the stop bit (the 11th) goes to ACKCHK.
  - ACKCHK, entered on that edge: samples synchronized DATA in the same cycle (`ackReg = !data`). Goes to WAITIDLE.
  - WAITIDLE: waits until filtered CLK = 1 and synchronized DATA = 1. Then pulses `done`, `ack = ackReg`, `err = !ackReg`, and returns to IDLE.
  - Timeout: in SEND, ACKCHK or WAITIDLE, the timeout counter reloads on each `fe` and decrements otherwise. Reaching 0 releases both lines and pulses `done` with `ack=0`, `err=1`. Then goes to IDLE.
- Boundary conditions:
  - `start` while `busy`: ignored. The latched byte does not change.
  - `start` in the same cycle as `done`: ignored. Accepted from the following cycle.
  - `fe` during INHIBIT/REQ: ignored, since the block is holding CLK low itself.
  - Reset in any state: next cycle both lines released, all outputs 0, state IDLE.
- Reset values: `busy`, `txActive`, `done`, `ack`, `err` all 0.

## Timing

- `busy` rises 1 cycle after `start`.
- `ps2CLK` is driven low from that same cycle for `INHIBIT_CYCLES` + 1 cycles. The final cycle overlaps DATA low.
- `ps2DATA` goes low 1 cycle before `ps2CLK` is released, and stays low until the first `fe`.
- Bit update latency: 2 (sync) + `FILTER_LEN` + 1 cycles after the physical falling edge. This is well inside the ≥30 µs device low phase.
- `done` and `busy` fall together. `done` is high for exactly 1 cycle.
- Worst-case attempt length: `INHIBIT_CYCLES` + 1 + 12·`EDGE_TIMEOUT` cycles.

## Test plan

- Send 0xED with a device model clocking at 12.5 kHz and ACKing -> DATA seen at device rising edges: 0,1,0,1,1,0,1,1,1,1(parity),1(stop). Then `done`=1, `ack`=1, `err`=0.
- Send 0x00, then 0x01 -> parity bits 1 and 0 respectively. Two back-to-back frames succeed, with `start` issued the cycle after `done`.
- Device model never drives ACK -> `done`=1, `ack`=0, `err`=1. Both lines released afterwards.
- Device never clocks (`EDGE_TIMEOUT`=1000 in the bench) -> `err` pulses 1001 cycles after CLK release, ±1. `busy` drops in the same cycle.
- `start` with `data`=0x55 pulsed mid-frame of 0xF3 -> transmitted byte stays 0xF3, and only one `done` occurs.
- `rst` asserted during bit 4 -> next cycle `ps2CLK`/`ps2DATA` are Z and `busy`=0. A new `start` of 0xFF then completes with `ack`=1.
